// File: rtl/ac97_sdata_in_deserializer.sv
// ac97_sdata_in_deserializer
//
// Controller-side receiver for the AC97 SDATA_IN stream. Runs entirely in the
// AC97 bit-clock domain. Frame boundaries come from the controller's own SYNC
// output: a SYNC rise marks frame bit 0, and that bit is sampled in the same
// cycle as the rise. The 256-bit frame is deserialized MSB-first, and the block
// extracts:
//   - the tag: codec ready flag plus the slot-valid bits for slots 1..4
//   - the status register readback (slot 1 address, slot 2 data)
//   - the left/right capture PCM samples (slots 3/4)
//
// Ports
//   clk_i             AC97 bit clock (only clock)
//   rst_i             synchronous active-high reset
//   sync_i            controller AUDIO_SYNC
//   sdata_in_i        codec AUDIO_SDATA_IN
//   sample_left_o     slot 3 sample, top SAMPLE_WIDTH bits
//   sample_right_o    slot 4 sample, top SAMPLE_WIDTH bits
//   sample_valid_o    sample pair valid
//   sample_ready_i    consumer accepts the pair
//   status_addr_o     slot 1 bits [18:12]
//   status_data_o     slot 2 bits [19:4]
//   status_valid_o    one-cycle pulse on a new status word
//   codec_ready_o     tag[15] of the last completed frame
//   overflow_o        sticky: a sample pair was dropped
//   overflow_clear_i  clears overflow_o (a simultaneous set wins)
//   frame_error_o     one-cycle pulse when frame alignment is lost
//   dbg_state_o       receiver state (0 = HUNT, 1 = RUN)
//
// Sample handshake: a transfer happens on every cycle where sample_valid_o and
// sample_ready_i are both 1. While sample_valid_o is 1 and sample_ready_i is 0
// the pair is held stable. sample_valid_o drops after a transfer unless a new
// pair is committed in that same cycle.
//
// Every output is driven straight from a register.

module ac97_sdata_in_deserializer #(
    parameter int SAMPLE_WIDTH = 20
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    sync_i,
    input  logic                    sdata_in_i,
    output logic [SAMPLE_WIDTH-1:0] sample_left_o,
    output logic [SAMPLE_WIDTH-1:0] sample_right_o,
    output logic                    sample_valid_o,
    input  logic                    sample_ready_i,
    output logic [6:0]              status_addr_o,
    output logic [15:0]             status_data_o,
    output logic                    status_valid_o,
    output logic                    codec_ready_o,
    output logic                    overflow_o,
    input  logic                    overflow_clear_i,
    output logic                    frame_error_o,
    output logic                    dbg_state_o
);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;          // frame bit index sampled last cycle
    logic                    sync_prev_q;
    logic [19:0]             shift_q, shift_d;
    logic [4:0]              tag_q, tag_d;          // tag[15:11]
    logic [6:0]              slot1_addr_q, slot1_addr_d;
    logic [SAMPLE_WIDTH-1:0] left_stage_q, left_stage_d;
    logic [SAMPLE_WIDTH-1:0] sample_left_q, sample_left_d;
    logic [SAMPLE_WIDTH-1:0] sample_right_q, sample_right_d;
    logic                    sample_valid_q, sample_valid_d;
    logic [6:0]              status_addr_q, status_addr_d;
    logic [15:0]             status_data_q, status_data_d;
    logic                    status_valid_q, status_valid_d;
    logic                    codec_ready_q, codec_ready_d;
    logic                    overflow_q, overflow_d;
    logic                    frame_error_q, frame_error_d;

    logic                    sync_rise;
    logic                    capture;
    logic [7:0]              bit_idx;
    logic [19:0]             shift_nx;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        tag_d          = tag_q;
        slot1_addr_d   = slot1_addr_q;
        left_stage_d   = left_stage_q;
        sample_left_d  = sample_left_q;
        sample_right_d = sample_right_q;
        sample_valid_d = sample_valid_q;
        status_addr_d  = status_addr_q;
        status_data_d  = status_data_q;
        status_valid_d = 1'b0;
        codec_ready_d  = codec_ready_q;
        overflow_d     = overflow_q;
        frame_error_d  = 1'b0;

        sync_rise = sync_i & ~sync_prev_q;
        // A bit belongs to a frame if it starts one, or if it continues a
        // running frame that has not yet reached bit 255.
        capture   = sync_rise | ((state_q == ST_RUN) && (cnt_q != 8'd255));
        bit_idx   = sync_rise ? 8'd0 : cnt_q + 8'd1;
        // Shifted value including the bit sampled this cycle, so each field
        // can be latched in the same cycle its last bit arrives.
        shift_nx  = {shift_q[18:0], sdata_in_i};

        // Frame tracking
        if (sync_rise) begin
            if ((state_q == ST_RUN) && (cnt_q != 8'd255)) begin
                frame_error_d = 1'b1;   // early SYNC: partial frame abandoned
            end
            state_d = ST_RUN;
            cnt_d   = 8'd0;
        end else if (state_q == ST_RUN) begin
            if (cnt_q == 8'd255) begin
                frame_error_d = 1'b1;   // no SYNC where the next frame should start
                state_d       = ST_HUNT;
                cnt_d         = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        // Consumer side of the sample handshake
        if (sample_valid_q && sample_ready_i) begin
            sample_valid_d = 1'b0;
        end

        // Clear first so that a set later in this block takes priority
        if (overflow_clear_i) begin
            overflow_d = 1'b0;
        end

        // Field extraction
        if (capture) begin
            shift_d = shift_nx;
            case (bit_idx)
                8'd15: tag_d = shift_nx[15:11];
                8'd35: slot1_addr_d = shift_nx[18:12];
                8'd55: begin
                    if (tag_q[3] && tag_q[2]) begin
                        status_addr_d  = slot1_addr_q;
                        status_data_d  = shift_nx[19:4];
                        status_valid_d = 1'b1;
                    end
                end
                8'd75: left_stage_d = shift_nx[19 -: SAMPLE_WIDTH];
                8'd95: begin
                    if (tag_q[1] && tag_q[0]) begin
                        if (!sample_valid_q || sample_ready_i) begin
                            sample_left_d  = left_stage_q;
                            sample_right_d = shift_nx[19 -: SAMPLE_WIDTH];
                            sample_valid_d = 1'b1;
                        end else begin
                            overflow_d = 1'b1;  // held pair wins, new pair dropped
                        end
                    end
                end
                8'd255: codec_ready_d = tag_q[4];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_HUNT;
            cnt_q          <= 8'd0;
            // Treat SYNC as already high so a level that is high when reset
            // releases is not mistaken for a frame start.
            sync_prev_q    <= 1'b1;
            shift_q        <= '0;
            tag_q          <= '0;
            slot1_addr_q   <= '0;
            left_stage_q   <= '0;
            sample_left_q  <= '0;
            sample_right_q <= '0;
            sample_valid_q <= 1'b0;
            status_addr_q  <= '0;
            status_data_q  <= '0;
            status_valid_q <= 1'b0;
            codec_ready_q  <= 1'b0;
            overflow_q     <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sync_prev_q    <= sync_i;
            shift_q        <= shift_d;
            tag_q          <= tag_d;
            slot1_addr_q   <= slot1_addr_d;
            left_stage_q   <= left_stage_d;
            sample_left_q  <= sample_left_d;
            sample_right_q <= sample_right_d;
            sample_valid_q <= sample_valid_d;
            status_addr_q  <= status_addr_d;
            status_data_q  <= status_data_d;
            status_valid_q <= status_valid_d;
            codec_ready_q  <= codec_ready_d;
            overflow_q     <= overflow_d;
            frame_error_q  <= frame_error_d;
        end
    end

    assign sample_left_o  = sample_left_q;
    assign sample_right_o = sample_right_q;
    assign sample_valid_o = sample_valid_q;
    assign status_addr_o  = status_addr_q;
    assign status_data_o  = status_data_q;
    assign status_valid_o = status_valid_q;
    assign codec_ready_o  = codec_ready_q;
    assign overflow_o     = overflow_q;
    assign frame_error_o  = frame_error_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ac97_sdata_in_deserializer.sv
module tb_ac97_sdata_in_deserializer;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sync, sdata, ready, ovf_clr;

  logic [19:0] left, right;
  logic        valid, status_valid, codec_ready, overflow, frame_error, dbg_state;
  logic [6:0]  status_addr;
  logic [15:0] status_data;

  logic [15:0] left16, right16;
  logic        valid16, status_valid16, codec_ready16, overflow16, frame_error16, dbg_state16;
  logic [6:0]  status_addr16;
  logic [15:0] status_data16;

  ac97_sdata_in_deserializer #(.SAMPLE_WIDTH(20)) dut (
    .clk_i(clk), .rst_i(rst), .sync_i(sync), .sdata_in_i(sdata),
    .sample_left_o(left), .sample_right_o(right), .sample_valid_o(valid),
    .sample_ready_i(ready), .status_addr_o(status_addr), .status_data_o(status_data),
    .status_valid_o(status_valid), .codec_ready_o(codec_ready), .overflow_o(overflow),
    .overflow_clear_i(ovf_clr), .frame_error_o(frame_error), .dbg_state_o(dbg_state)
  );

  ac97_sdata_in_deserializer #(.SAMPLE_WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .sync_i(sync), .sdata_in_i(sdata),
    .sample_left_o(left16), .sample_right_o(right16), .sample_valid_o(valid16),
    .sample_ready_i(ready), .status_addr_o(status_addr16), .status_data_o(status_data16),
    .status_valid_o(status_valid16), .codec_ready_o(codec_ready16), .overflow_o(overflow16),
    .overflow_clear_i(ovf_clr), .frame_error_o(frame_error16), .dbg_state_o(dbg_state16)
  );

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];     // {left, right} for the 20-bit instance
  logic [31:0] exp16_q[$];   // {left, right} for the 16-bit instance
  logic [22:0] stat_q[$];    // {addr, data}

  int ferr_cnt = 0;
  int stat_cnt = 0;
  int valid_cycles = 0;
  int rise_edge = 0;
  int start_edge = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic        hold_prev, hold16_prev, prev_v;
    logic [19:0] hold_l, hold_r;
    logic [15:0] hold16_l, hold16_r;
    logic [39:0] e;
    logic [31:0] e16;
    logic [22:0] es;
    hold_prev = 1'b0; hold16_prev = 1'b0; prev_v = 1'b0;
    hold_l = '0; hold_r = '0; hold16_l = '0; hold16_r = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev   = 1'b0;
        hold16_prev = 1'b0;
      end else begin
        if (frame_error) ferr_cnt++;
        if (status_valid) begin
          stat_cnt++;
          if (stat_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL status_unexpected actual=%0h/%0h expected=none", status_addr, status_data);
          end else begin
            es = stat_q.pop_front();
            check("status_addr", 64'(status_addr), 64'(es[22:16]));
            check("status_data", 64'(status_data), 64'(es[15:0]));
          end
        end
        if (hold_prev) begin
          check("hold_valid", 64'(valid), 64'(1'b1));
          check("hold_left", 64'(left), 64'(hold_l));
          check("hold_right", 64'(right), 64'(hold_r));
        end
        if (hold16_prev) begin
          check("hold16_left", 64'(left16), 64'(hold16_l));
          check("hold16_right", 64'(right16), 64'(hold16_r));
        end
        if (valid && !prev_v) rise_edge = cyc + 1;
        if (valid) valid_cycles++;
        if (valid && ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sample_unexpected actual=%0h/%0h expected=none", left, right);
          end else begin
            e = exp_q.pop_front();
            check("sample_left", 64'(left), 64'(e[39:20]));
            check("sample_right", 64'(right), 64'(e[19:0]));
          end
        end
        if (valid16 && ready) begin
          if (exp16_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sample16_unexpected actual=%0h/%0h expected=none", left16, right16);
          end else begin
            e16 = exp16_q.pop_front();
            check("sample16_left", 64'(left16), 64'(e16[31:16]));
            check("sample16_right", 64'(right16), 64'(e16[15:0]));
          end
        end
        hold_prev   = valid && !ready;
        hold_l      = left;
        hold_r      = right;
        hold16_prev = valid16 && !ready;
        hold16_l    = left16;
        hold16_r    = right16;
      end
      prev_v = valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk(input logic [15:0] tag, input logic [19:0] s1,
                                      input logic [19:0] s2, input logic [19:0] s3,
                                      input logic [19:0] s4);
    return {tag, s1, s2, s3, s4, 160'b0};
  endfunction

  // Drives frame bits from..to; each bit is sampled at the following posedge.
  task automatic send_bits(input logic [255:0] f, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      tick();
      if (i == 0) start_edge = cyc + 1;
      sync  = (i < 16);
      sdata = f[255-i];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      sync  = 1'b0;
      sdata = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_left"}, 64'(left), 64'd0);
    check({tag, "_right"}, 64'(right), 64'd0);
    check({tag, "_valid"}, 64'(valid), 64'd0);
    check({tag, "_saddr"}, 64'(status_addr), 64'd0);
    check({tag, "_sdata"}, 64'(status_data), 64'd0);
    check({tag, "_svalid"}, 64'(status_valid), 64'd0);
    check({tag, "_cready"}, 64'(codec_ready), 64'd0);
    check({tag, "_ovf"}, 64'(overflow), 64'd0);
    check({tag, "_ferr"}, 64'(frame_error), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
    check({tag, "_left16"}, 64'(left16), 64'd0);
    check({tag, "_valid16"}, 64'(valid16), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] f;
    int v0, s0, f1_start;
    rst = 1'b1; sync = 1'b0; sdata = 1'b0; ready = 1'b1; ovf_clr = 1'b0;
    repeat (4) tick();
    check_all_zero("reset");
    rst = 1'b0;
    idle(2);

    // Normal frame: tag 0x9800, both sample slots valid
    f = mk(16'h9800, 20'h0, 20'h0, 20'h12345, 20'hABCDE);
    exp_q.push_back({20'h12345, 20'hABCDE});
    exp16_q.push_back({16'h1234, 16'hABCD});
    v0 = valid_cycles;
    send_bits(f, 0, 0);
    f1_start = start_edge;
    send_bits(f, 1, 127);
    check("codec_ready_mid_f1", 64'(codec_ready), 64'd0);
    send_bits(f, 128, 255);

    // Sample slots flagged invalid
    f = mk(16'h8000, 20'h0, 20'h0, 20'h0F0F0, 20'h0A0A0);
    send_bits(f, 0, 0);
    check("codec_ready_f1", 64'(codec_ready), 64'd1);
    check("f1_valid_cycles", 64'(valid_cycles - v0), 64'd1);
    check("f1_latency", 64'(rise_edge - f1_start), 64'd96);
    check("f1_ferr", 64'(ferr_cnt), 64'd0);
    v0 = valid_cycles;
    send_bits(f, 1, 255);

    // Status readback
    f = mk(16'hE000, 20'h26000, 20'h000F0, 20'h11111, 20'h22222);
    stat_q.push_back({7'h26, 16'h000F});
    s0 = stat_cnt;
    send_bits(f, 0, 0);
    check("f2_no_valid", 64'(valid_cycles - v0), 64'd0);
    send_bits(f, 1, 255);

    // Backpressure: two valid frames while not ready
    ready = 1'b0;
    f = mk(16'h9800, 20'h0, 20'h0, 20'h11111, 20'h22222);
    exp_q.push_back({20'h11111, 20'h22222});
    exp16_q.push_back({16'h1111, 16'h2222});
    send_bits(f, 0, 0);
    check("status_pulses", 64'(stat_cnt - s0), 64'd1);
    send_bits(f, 1, 255);
    f = mk(16'h9800, 20'h0, 20'h0, 20'h33333, 20'h44444);
    send_bits(f, 0, 95);
    check("ovf_before", 64'(overflow), 64'd0);
    send_bits(f, 96, 96);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf16_set", 64'(overflow16), 64'd1);
    check("held_left", 64'(left), 64'h11111);
    check("held_right", 64'(right), 64'h22222);
    check("held_valid", 64'(valid), 64'd1);
    send_bits(f, 97, 255);
    f = mk(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0);
    send_bits(f, 0, 0);
    ready = 1'b1;
    send_bits(f, 1, 9);
    check("ovf_sticky", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    send_bits(f, 10, 10);
    ovf_clr = 1'b0;
    send_bits(f, 11, 11);
    check("ovf_cleared", 64'(overflow), 64'd0);
    check("ovf16_cleared", 64'(overflow16), 64'd0);
    check("drained_after_bp", 64'(exp_q.size()), 64'd0);
    send_bits(f, 12, 255);

    // Early sync at bit 100, next frame starts at that rise
    f = mk(16'h9800, 20'h0, 20'h0, 20'h55555, 20'h66666);
    exp_q.push_back({20'h55555, 20'h66666});
    exp16_q.push_back({16'h5555, 16'h6666});
    send_bits(f, 0, 99);
    f = mk(16'h9800, 20'h0, 20'h0, 20'h7ABCD, 20'h80001);
    exp_q.push_back({20'h7ABCD, 20'h80001});
    exp16_q.push_back({16'h7ABC, 16'h8000});
    send_bits(f, 0, 3);
    check("early_sync_ferr", 64'(ferr_cnt), 64'd1);
    send_bits(f, 4, 255);

    // Missing sync at wrap
    idle(4);
    check("wrap_ferr", 64'(ferr_cnt), 64'd2);
    check("wrap_state", 64'(dbg_state), 64'd0);
    check("wrap_state16", 64'(dbg_state16), 64'd0);
    check("wrap_cready", 64'(codec_ready), 64'd1);

    // Reset at bit 60 of a valid frame
    f = mk(16'h9800, 20'h0, 20'h0, 20'h0AAAA, 20'h0BBBB);
    send_bits(f, 0, 60);
    rst = 1'b1;
    tick();
    check_all_zero("midreset");
    rst = 1'b0;
    idle(3);

    // Full frame after reset; 16-bit instance truncates 0xFFFF0 to 0xFFFF
    f = mk(16'h9800, 20'h0, 20'h0, 20'hFFFF0, 20'h00010);
    exp_q.push_back({20'hFFFF0, 20'h00010});
    exp16_q.push_back({16'hFFFF, 16'h0001});
    send_bits(f, 0, 255);
    idle(4);
    check("final_cready", 64'(codec_ready), 64'd1);
    check("final_ferr", 64'(ferr_cnt), 64'd3);

    for (int i = 0; i < 300 && (exp_q.size() != 0 || exp16_q.size() != 0); i++) tick();
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("exp16_q_empty", 64'(exp16_q.size()), 64'd0);
    check("stat_q_empty", 64'(stat_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
